// File: rtl/tc_pkg.sv
// Shared types and helpers for the TC family of delay-line arbiters.
package tc_pkg;

    // Upper bounds for the tag and data fields carried through a delay stage.
    // Instances use the low ID_W / BIT_WIDTH bits; the rest stay zero.
    localparam int DL_ID_MAX   = 8;
    localparam int DL_DATA_MAX = 64;

    // One delay-line stage: occupancy flag, requester tag and payload.
    typedef struct packed {
        logic                   valid;
        logic [DL_ID_MAX-1:0]   id;
        logic [DL_DATA_MAX-1:0] data;
    } dl_stage_t;

    // Width of a round-robin pointer covering n requesters.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, with wrap.
module tc_rr_pick
    import tc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tc_delay_line_arbiter.sv
// Round-robin scheduler sharing one fixed-latency delay line among NUM_REQ
// requesters. Granted words shift through DEPTH stages tagged with their id;
// the head stage drives the response and the whole line stalls on back-pressure.
module tc_delay_line_arbiter
    import tc_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 2,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [BIT_WIDTH-1:0]         resp_data,
    input  logic                         resp_ready
);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("tc_delay_line_arbiter: NUM_REQ must be at least 2");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("tc_delay_line_arbiter: DEPTH must be at least 1");
    end
    if (ID_W > DL_ID_MAX || BIT_WIDTH > DL_DATA_MAX) begin : g_bad_width
        $error("tc_delay_line_arbiter: ID_W or BIT_WIDTH exceeds stage field width");
    end

    dl_stage_t            stage [DEPTH];
    dl_stage_t            new_stage;
    logic [ID_W-1:0]      ptr;
    logic                 advance;
    logic [NUM_REQ-1:0]   req_gated;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;

    // The line moves whenever the head is empty or being consumed; grants are
    // suppressed during a stall and while reset is held.
    assign advance   = !stage[DEPTH-1].valid || resp_ready;
    assign req_gated = (advance && !rst) ? req : '0;

    tc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_gated),
        .ptr   (ptr),
        .grant (grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    // Build the word entering stage 0: the granted request, or a bubble.
    always_comb begin
        new_stage = '0;
        if (pick_any) begin
            new_stage.valid                = 1'b1;
            new_stage.id[ID_W-1:0]         = pick_id;
            new_stage.data[BIT_WIDTH-1:0]  = req_data[int'(pick_id)*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    // Fixed shift toward the head on advance; pointer moves past each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            ptr <= '0;
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) stage[k] <= stage[k-1];
            stage[0] <= new_stage;
            if (pick_any) begin
                ptr <= (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + 1'b1;
            end
        end
    end

    assign resp_valid = stage[DEPTH-1].valid;
    assign resp_id    = stage[DEPTH-1].id[ID_W-1:0];
    assign resp_data  = stage[DEPTH-1].data[BIT_WIDTH-1:0];

endmodule

// File: tb/tb_tc_delay_line_arbiter.sv
// Randomised and directed bench for tc_delay_line_arbiter against a
// queue-based behavioural model of the response stream.
module tb_tc_delay_line_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int BIT_WIDTH = 8;
    localparam int DEPTH     = 2;
    localparam int ID_W      = 2;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NUM_REQ-1:0]           req = '0;
    logic [NUM_REQ*BIT_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]           grant;
    logic                         resp_valid;
    logic [ID_W-1:0]              resp_id;
    logic [BIT_WIDTH-1:0]         resp_data;
    logic                         resp_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    tc_delay_line_arbiter #(
        .NUM_REQ(NUM_REQ), .BIT_WIDTH(BIT_WIDTH), .DEPTH(DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    // Model: the response stream is a queue of DEPTH entries; head is index 0.
    typedef struct { bit v; int id; int data; } ent_t;
    ent_t mq[$];
    int   mptr;

    logic [NUM_REQ-1:0]   exp_grant;
    logic                 exp_valid;
    logic [ID_W-1:0]      exp_id;
    logic [BIT_WIDTH-1:0] exp_data;
    bit                   exp_adv;
    int                   exp_gid;

    task automatic model_reset();
        ent_t z;
        z.v = 0; z.id = 0; z.data = 0;
        mq.delete();
        for (int k = 0; k < DEPTH; k++) mq.push_back(z);
        mptr = 0;
    endtask

    task automatic model_eval();
        ent_t h;
        h = mq[0];
        exp_adv   = !h.v || resp_ready;
        exp_grant = '0;
        exp_gid   = -1;
        if (!rst && exp_adv) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (mptr + k) % NUM_REQ;
                if (exp_gid < 0 && req[i]) begin
                    exp_gid      = i;
                    exp_grant[i] = 1'b1;
                end
            end
        end
        exp_valid = h.v;
        exp_id    = ID_W'(h.id);
        exp_data  = BIT_WIDTH'(h.data);
    endtask

    task automatic model_commit();
        ent_t e;
        e.v = 0; e.id = 0; e.data = 0;
        if (rst) begin
            model_reset();
        end else if (exp_adv) begin
            if (exp_gid >= 0) begin
                e.v    = 1;
                e.id   = exp_gid;
                e.data = int'((req_data >> (exp_gid * BIT_WIDTH)) & 32'hFF);
                mptr   = (exp_gid + 1) % NUM_REQ;
            end
            void'(mq.pop_front());
            mq.push_back(e);
        end
    endtask

    // Apply inputs away from the active edge, then compute expectations.
    task automatic drive(input logic [NUM_REQ-1:0] r, input logic [31:0] d,
                         input logic rd, input logic rs);
        @(negedge clk);
        req = r; req_data = d; resp_ready = rd; rst = rs;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    task automatic test_reset();
        drive('0, '0, 1'b1, 1'b1); tick();
        drive('0, '0, 1'b1, 1'b1); tick();
        drive(4'b0110, $urandom, 1'b1, 1'b0); tick();
        drive(4'b0110, $urandom, 1'b1, 1'b0); tick();
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, $urandom, 1'b1, 1'b1);
            checks++;
            if (grant !== 4'b0000) begin
                errors++; $display("FAIL reset_grant: got %b expected 0000", grant);
            end
            tick();
        end
        drive(4'b0001, 32'h00000055, 1'b1, 1'b0);
        checks++;
        if ({resp_valid, resp_id, resp_data} !== '0) begin
            errors++; $display("FAIL reset_resp: got v=%b id=%0d d=%h expected all zero",
                               resp_valid, resp_id, resp_data);
        end
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 0001", grant);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive('0, '0, 1'b1, 1'b0);
            checks++;
            if (resp_valid !== exp_valid || (exp_valid && (resp_id !== exp_id || resp_data !== exp_data))) begin
                errors++; $display("FAIL reset_drain: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h",
                                   resp_valid, resp_id, resp_data, exp_valid, exp_id, exp_data);
            end
            tick();
        end
    endtask

    task automatic test_single();
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 3; c++) begin drive('0, '0, 1'b1, 1'b0); tick(); end
        drive(4'b0010, 32'h00003C00, 1'b1, 1'b0);
        checks++;
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL single_grant: got %b expected 0010", grant);
        end
        tick();
        drive('0, '0, 1'b1, 1'b0);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got resp_valid=%b expected 0", resp_valid);
        end
        tick();
        drive('0, '0, 1'b1, 1'b0);
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'h3C) begin
            errors++; $display("FAIL single_resp: got v=%b id=%0d d=%h expected v=1 id=1 d=3c",
                               resp_valid, resp_id, resp_data);
        end
        tick();
    endtask

    task automatic test_all_requesting();
        int order[5] = '{0, 1, 2, 3, 0};
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, $urandom, 1'b1, 1'b0);
            checks++;
            if (grant !== exp_grant || (c < 5 && grant !== (4'b0001 << order[c]))) begin
                errors++; $display("FAIL all_grant[%0d]: got %b expected %b", c, grant, exp_grant);
            end
            if (c >= DEPTH) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_id !== ID_W'((c - DEPTH) % NUM_REQ)
                    || resp_data !== exp_data) begin
                    errors++; $display("FAIL all_resp[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                                       c, resp_valid, resp_id, resp_data, exp_id, exp_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [NUM_REQ-1:0] pat[4] = '{4'b0100, 4'b1001, 4'b0001, 4'b0011};
        logic [NUM_REQ-1:0] want[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 4; c++) begin
            drive(pat[c], $urandom, 1'b1, 1'b0);
            checks++;
            if (grant !== want[c] || grant !== exp_grant) begin
                errors++; $display("FAIL wrap_grant[%0d]: got %b expected %b", c, grant, want[c]);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        int got[$];
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 3; c++) begin drive(4'b1111, $urandom, 1'b1, 1'b0);
            if (resp_valid && resp_ready) got.push_back(int'(resp_id));
            tick(); end
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, $urandom, 1'b0, 1'b0);
            checks++;
            if (grant !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== exp_data) begin
                errors++; $display("FAIL bp_stall[%0d]: got g=%b v=%b id=%0d d=%h expected g=0000 v=1 id=%0d d=%h",
                                   c, grant, resp_valid, resp_id, resp_data, exp_id, exp_data);
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive('0, '0, 1'b1, 1'b0);
            checks++;
            if (resp_valid !== exp_valid || (exp_valid && (resp_id !== exp_id || resp_data !== exp_data))) begin
                errors++; $display("FAIL bp_drain[%0d]: got v=%b id=%0d expected v=%b id=%0d",
                                   c, resp_valid, resp_id, exp_valid, exp_id);
            end
            if (resp_valid && resp_ready) got.push_back(int'(resp_id));
            tick();
        end
        checks++;
        if (got.size() != 3 || got[0] != 0 || got[1] != 1 || got[2] != 2) begin
            errors++; $display("FAIL bp_order: got %0d words %p expected ids 0,1,2", got.size(), got);
        end
    endtask

    task automatic test_bubble();
        logic [NUM_REQ-1:0] pat[7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic               vexp[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 7; c++) begin
            drive(pat[c], $urandom, 1'b1, 1'b0);
            checks++;
            if (resp_valid !== vexp[c] || resp_valid !== exp_valid) begin
                errors++; $display("FAIL bubble_valid[%0d]: got %b expected %b", c, resp_valid, vexp[c]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend = '0;
        drive('0, '0, 1'b1, 1'b1); tick();
        for (int c = 0; c < 600; c++) begin
            logic rs;
            logic rd;
            pend = pend | NUM_REQ'($urandom & $urandom);
            rd   = ($urandom_range(0, 9) < 7);
            rs   = ($urandom_range(0, 99) < 2);
            drive(pend, $urandom, rd, rs);
            checks++;
            if (grant !== exp_grant || resp_valid !== exp_valid
                || (exp_valid && (resp_id !== exp_id || resp_data !== exp_data))) begin
                errors++; $display("FAIL random[%0d]: got g=%b v=%b id=%0d d=%h expected g=%b v=%b id=%0d d=%h",
                                   c, grant, resp_valid, resp_id, resp_data,
                                   exp_grant, exp_valid, exp_id, exp_data);
            end
            if (rs) pend = '0;
            else    pend = pend & ~exp_grant;
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_requesting();
        test_wrap();
        test_back_pressure();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
